// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition-code encodings and PSR flag bit positions.
// Imported by the execute flag stage and the condition evaluator.
package cpu_pkg;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  // PSR layout is {v,c,n,z}, MSB first.
  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

endpackage

// File: rtl/cond_eval.sv
// Purely combinational condition-code evaluator: decides whether a 4-bit
// condition passes against a {v,c,n,z} flag set. Also used by the branch predictor.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic flagV;
  logic flagC;
  logic flagN;
  logic flagZ;

  assign flagV = flags_i[FLAG_V];
  assign flagC = flags_i[FLAG_C];
  assign flagN = flags_i[FLAG_N];
  assign flagZ = flags_i[FLAG_Z];

  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = flagZ;
      COND_NE: pass_o = ~flagZ;
      COND_CS: pass_o = flagC;
      COND_CC: pass_o = ~flagC;
      COND_MI: pass_o = flagN;
      COND_PL: pass_o = ~flagN;
      COND_VS: pass_o = flagV;
      COND_VC: pass_o = ~flagV;
      COND_HI: pass_o = flagC & ~flagZ;
      COND_LS: pass_o = ~flagC | flagZ;
      COND_GE: pass_o = (flagN == flagV);
      COND_LT: pass_o = (flagN != flagV);
      COND_GT: pass_o = ~flagZ & (flagN == flagV);
      COND_LE: pass_o = flagZ | (flagN != flagV);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b0;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_flag_stage.sv
// Execute-to-writeback stage: registers the ALU result behind a valid/ready slot,
// owns the architectural PSR, gates write-back/branches on condition codes, counts retirements.
module ex_flag_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  input  logic              set_flags,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [3:0]        cond,
  input  logic              is_branch,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_wr_en,
  output logic [REG_AW-1:0] out_wr_addr,
  output logic              branch_taken,
  output logic [3:0]        psr,
  output logic [CNT_W-1:0]  retired
);

  logic              outValid_q,  outValid_d;
  logic [DATA_W-1:0] outResult_q, outResult_d;
  logic              outWrEn_q,   outWrEn_d;
  logic [REG_AW-1:0] outWrAddr_q, outWrAddr_d;
  logic              branch_q,    branch_d;
  logic [3:0]        psr_q,       psr_d;
  logic [CNT_W-1:0]  retired_q,   retired_d;

  logic condPass;
  logic accept;

  // Condition is judged against the committed PSR, never the incoming ALU flags.
  cond_eval u_cond_eval (
    .cond_i  (cond),
    .flags_i (psr_q),
    .pass_o  (condPass)
  );

  assign in_ready = ~outValid_q | out_ready;
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    outValid_d  = outValid_q;
    outResult_d = outResult_q;
    outWrEn_d   = outWrEn_q;
    outWrAddr_d = outWrAddr_q;
    branch_d    = branch_q;
    psr_d       = psr_q;
    retired_d   = retired_q;

    if (flush) begin
      outValid_d = 1'b0;
      outWrEn_d  = 1'b0;
      branch_d   = 1'b0;
    end else if (accept) begin
      outValid_d  = 1'b1;
      outResult_d = alu_result;
      outWrAddr_d = wr_addr;
      outWrEn_d   = wr_en & condPass;
      branch_d    = is_branch & condPass;
      retired_d   = retired_q + CNT_W'(1);
      if (set_flags & condPass) begin
        psr_d = alu_flags;
      end
    end else if (out_ready) begin
      // Drained with nothing behind it: side-effect strobes must not linger.
      outValid_d = 1'b0;
      outWrEn_d  = 1'b0;
      branch_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outValid_q  <= 1'b0;
      outResult_q <= '0;
      outWrEn_q   <= 1'b0;
      outWrAddr_q <= '0;
      branch_q    <= 1'b0;
      psr_q       <= '0;
      retired_q   <= '0;
    end else begin
      outValid_q  <= outValid_d;
      outResult_q <= outResult_d;
      outWrEn_q   <= outWrEn_d;
      outWrAddr_q <= outWrAddr_d;
      branch_q    <= branch_d;
      psr_q       <= psr_d;
      retired_q   <= retired_d;
    end
  end

  assign out_valid    = outValid_q;
  assign out_result   = outResult_q;
  assign out_wr_en    = outWrEn_q;
  assign out_wr_addr  = outWrAddr_q;
  assign branch_taken = branch_q;
  assign psr          = psr_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_ex_flag_stage.sv
// Scoreboard bench for ex_flag_stage: directed instructions push hand-computed
// write-back entries; a monitor pops and compares them on every output handshake.
module tb_ex_flag_stage;
  import cpu_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] alu_result;
  logic [3:0]    alu_flags;
  logic          set_flags;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    cond;
  logic          is_branch;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic          out_wr_en;
  logic [AW-1:0] out_wr_addr;
  logic          branch_taken;
  logic [3:0]    psr;
  logic [CW-1:0] retired;

  typedef struct packed {
    logic [DW-1:0] result;
    logic          wrEn;
    logic [AW-1:0] wrAddr;
    logic          br;
  } exp_t;

  exp_t       expQ[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] expRetired;

  ex_flag_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_result   (alu_result),
    .alu_flags    (alu_flags),
    .set_flags    (set_flags),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .cond         (cond),
    .is_branch    (is_branch),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_wr_en    (out_wr_en),
    .out_wr_addr  (out_wr_addr),
    .branch_taken (branch_taken),
    .psr          (psr),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents one instruction from posedge+2 and holds it until the stage takes it.
  task automatic applyStimulus(input logic [DW-1:0] res, input logic [3:0] flags,
                               input logic setf, input logic wr, input logic [AW-1:0] addr,
                               input logic [3:0] cc, input logic br,
                               input logic expWr, input logic expBr);
    int waitCycles = 0;
    in_valid   = 1'b1;
    alu_result = res;
    alu_flags  = flags;
    set_flags  = setf;
    wr_en      = wr;
    wr_addr    = addr;
    cond       = cc;
    is_branch  = br;
    @(negedge clk);
    while (!in_ready && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept timeout: in_ready got 0, expected 1");
    end else begin
      expQ.push_back('{res, expWr, addr, expBr});
      expRetired++;
    end
    @(posedge clk);
    #2;
    in_valid  = 1'b0;
    set_flags = 1'b0;
    wr_en     = 1'b0;
    is_branch = 1'b0;
  endtask

  // Monitor: every consumed write-back entry must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected entry: got result 0x%08h, expected none", out_result);
        end else begin
          e = expQ.pop_front();
          checkOutput("wb result", out_result, e.result);
          checkOutput("wb wr_en", 32'(out_wr_en), 32'(e.wrEn));
          checkOutput("wb wr_addr", 32'(out_wr_addr), 32'(e.wrAddr));
          checkOutput("wb branch_taken", 32'(branch_taken), 32'(e.br));
        end
      end
    end
  end

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b1;
    alu_result = '0;
    alu_flags  = 4'b0000;
    set_flags  = 1'b1;
    wr_en      = 1'b1;
    wr_addr    = '0;
    cond       = COND_AL;
    is_branch  = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b1;
    expRetired = '0;

    // Reset held two cycles with a valid instruction present.
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset psr", 32'(psr), 32'h0);
    checkOutput("reset out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset retired", 32'(retired), 32'h0);
    @(posedge clk);
    #2;
    reset     = 1'b0;
    in_valid  = 1'b0;
    set_flags = 1'b0;
    wr_en     = 1'b0;
    @(negedge clk);
    checkOutput("in_ready after reset", 32'(in_ready), 32'h1);
    checkOutput("psr after reset", 32'(psr), 32'h0);
    @(posedge clk);
    #2;

    // Flag chain: AL sets z, EQ then sees it.
    applyStimulus(32'h0000_0011, 4'b0001, 1'b1, 1'b0, 4'd1, COND_AL, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0000_0022, 4'b0000, 1'b0, 1'b1, 4'd2, COND_EQ, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("psr after AL set", 32'(psr), 32'h1);
    checkOutput("EQ out_wr_en", 32'(out_wr_en), 32'h1);
    @(posedge clk);
    #2;
    @(negedge clk);
    checkOutput("idle out_valid", 32'(out_valid), 32'h0);
    checkOutput("idle out_wr_en cleared", 32'(out_wr_en), 32'h0);
    @(posedge clk);
    #2;
    applyStimulus(32'h0000_0033, 4'b0000, 1'b0, 1'b1, 4'd3, COND_NE, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("NE out_valid", 32'(out_valid), 32'h1);
    checkOutput("NE out_wr_en", 32'(out_wr_en), 32'h0);
    @(posedge clk);
    #2;

    // Signed compare with v=1, n=0: GE fails, LT passes, NV never writes psr.
    applyStimulus(32'h0000_0044, 4'b1000, 1'b1, 1'b0, 4'd4, COND_AL, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0000_0055, 4'b0000, 1'b0, 1'b0, 4'd5, COND_GE, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h0000_0066, 4'b0000, 1'b0, 1'b1, 4'd6, COND_LT, 1'b1, 1'b1, 1'b1);
    applyStimulus(32'h0000_0077, 4'b0101, 1'b1, 1'b1, 4'd7, COND_NV, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("psr after NV set", 32'(psr), 32'h8);
    @(posedge clk);
    #2;

    // Backpressure: hold 0xDEADBEEF three cycles, then drain and load together.
    out_ready = 1'b0;
    applyStimulus(32'hDEAD_BEEF, 4'b0000, 1'b0, 1'b1, 4'd5, COND_AL, 1'b0, 1'b1, 1'b0);
    in_valid   = 1'b1;
    alu_result = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall in_ready", 32'(in_ready), 32'h0);
      checkOutput("stall out_result", out_result, 32'hDEAD_BEEF);
      @(posedge clk);
      #2;
    end
    checkOutput("stall retired", 32'(retired), 32'(expRetired));
    out_ready = 1'b1;
    applyStimulus(32'h1234_5678, 4'b0000, 1'b0, 1'b1, 4'd6, COND_AL, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("no-bubble out_valid", 32'(out_valid), 32'h1);
    checkOutput("no-bubble out_result", out_result, 32'h1234_5678);
    checkOutput("retired after backpressure", 32'(retired), 32'(expRetired));
    @(posedge clk);
    #2;

    // Flush a stalled entry together with an incoming flag-setting instruction.
    out_ready = 1'b0;
    applyStimulus(32'hAAAA_5555, 4'b0000, 1'b0, 1'b1, 4'd7, COND_AL, 1'b1, 1'b1, 1'b1);
    in_valid  = 1'b1;
    set_flags = 1'b1;
    cond      = COND_AL;
    alu_flags = 4'b1111;
    flush     = 1'b1;
    @(posedge clk);
    #2;
    flush     = 1'b0;
    in_valid  = 1'b0;
    set_flags = 1'b0;
    void'(expQ.pop_back());
    @(negedge clk);
    checkOutput("flush out_valid", 32'(out_valid), 32'h0);
    checkOutput("flush out_wr_en", 32'(out_wr_en), 32'h0);
    checkOutput("flush branch_taken", 32'(branch_taken), 32'h0);
    checkOutput("flush psr", 32'(psr), 32'h8);
    checkOutput("flush retired", 32'(retired), 32'(expRetired));
    @(posedge clk);
    #2;
    out_ready = 1'b1;

    // Counter wrap: 17 accepts on a 4-bit counter leave it at 1.
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset      = 1'b0;
    expRetired = '0;
    checkOutput("queue empty before wrap", 32'(expQ.size()), 32'h0);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(32'(i), 4'b0000, 1'b0, 1'b1, i[3:0], COND_AL, 1'b0, 1'b1, 1'b0);
    end
    @(negedge clk);
    checkOutput("retired wrap", 32'(retired), 32'h1);
    @(posedge clk);
    #2;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
